// File: rtl/i2c_cmd_arbiter.sv
// Two-requester I2C transaction arbiter. Grants one requester round-robin,
// then walks the START/WRITE/READ/STOP command sequence through a byte engine
// one command at a time, with ACK checking and a per-command timeout.
module i2c_cmd_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rw,
  input  logic [13:0] req_dev,
  input  logic [15:0] req_reg,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic        rsp_err,
  output logic [7:0]  rsp_rdata,
  output logic [2:0]  eng_cmd,
  output logic        eng_cmd_valid,
  input  logic        eng_cmd_ready,
  output logic [7:0]  eng_wdata,
  output logic        eng_nack,
  input  logic        eng_done,
  input  logic        eng_ack,
  input  logic [7:0]  eng_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_STOP  = 3'd4;

  state_t      state, state_d;
  logic [2:0]  step, step_d;
  logic [15:0] tmo, tmo_d;
  logic        owner, owner_d;
  logic        last, last_d;
  logic        lat_rw, lat_rw_d;
  logic [6:0]  lat_dev, lat_dev_d;
  logic [7:0]  lat_reg, lat_reg_d;
  logic [7:0]  lat_wdata, lat_wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        gnt_sel;
  logic [2:0]  cur_cmd;
  logic [7:0]  cur_byte;
  logic [2:0]  stop_step;
  logic        tmo_hit;

  // Map the sequence step (and direction) to the engine command and byte.
  always_comb begin
    cur_cmd  = CMD_STOP;
    cur_byte = 8'h00;
    case (step)
      3'd0: cur_cmd = CMD_START;
      3'd1: begin cur_cmd = CMD_WRITE; cur_byte = {lat_dev, 1'b0}; end
      3'd2: begin cur_cmd = CMD_WRITE; cur_byte = lat_reg; end
      3'd3: begin
        if (lat_rw) cur_cmd = CMD_START;
        else begin cur_cmd = CMD_WRITE; cur_byte = lat_wdata; end
      end
      3'd4: begin
        if (lat_rw) begin cur_cmd = CMD_WRITE; cur_byte = {lat_dev, 1'b1}; end
      end
      3'd5: if (lat_rw) cur_cmd = CMD_READ;
      default: cur_cmd = CMD_STOP;
    endcase
  end

  assign stop_step = lat_rw ? 3'd6 : 3'd4;
  assign tmo_hit   = ({1'b0, tmo} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};
  // With both requesting, serve the one not served last; otherwise the sole one.
  assign gnt_sel   = (req_valid == 2'b11) ? ~last : req_valid[1];

  // Next-state, datapath capture and all outputs.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d       = state;
    step_d        = step;
    tmo_d         = tmo;
    owner_d       = owner;
    last_d        = last;
    lat_rw_d      = lat_rw;
    lat_dev_d     = lat_dev;
    lat_reg_d     = lat_reg;
    lat_wdata_d   = lat_wdata;
    rdata_d       = rdata_q;
    err_d         = err_q;
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_err       = 1'b0;
    rsp_rdata     = 8'h00;
    eng_cmd       = CMD_NONE;
    eng_cmd_valid = 1'b0;
    eng_wdata     = 8'h00;
    eng_nack      = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (|req_valid)) begin
          req_ready   = gnt_sel ? 2'b10 : 2'b01;
          owner_d     = gnt_sel;
          last_d      = gnt_sel;
          lat_rw_d    = req_rw[gnt_sel];
          lat_dev_d   = gnt_sel ? req_dev[13:7]    : req_dev[6:0];
          lat_reg_d   = gnt_sel ? req_reg[15:8]    : req_reg[7:0];
          lat_wdata_d = gnt_sel ? req_wdata[15:8]  : req_wdata[7:0];
          rdata_d     = 8'h00;
          err_d       = 1'b0;
          step_d      = 3'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        eng_cmd_valid = 1'b1;
        eng_cmd       = cur_cmd;
        eng_wdata     = (cur_cmd == CMD_WRITE) ? cur_byte : 8'h00;
        eng_nack      = (cur_cmd == CMD_READ);
        if (eng_cmd_ready) begin
          tmo_d   = 16'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (eng_done) begin
          if (cur_cmd == CMD_STOP) begin
            state_d = RESP;
          end else if ((cur_cmd == CMD_WRITE) && !eng_ack) begin
            err_d   = 1'b1;
            step_d  = stop_step;
            state_d = ISSUE;
          end else begin
            if (cur_cmd == CMD_READ) rdata_d = eng_rdata;
            step_d  = step + 3'd1;
            state_d = ISSUE;
          end
        end else if (tmo_hit) begin
          // Abandon the command outright; the engine owns bus recovery.
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo + 16'd1;
        end
      end
      RESP: begin
        rsp_valid = owner ? 2'b10 : 2'b01;
        rsp_err   = err_q;
        rsp_rdata = err_q ? 8'h00 : rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      step      <= 3'd0;
      tmo       <= 16'd0;
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_rw    <= 1'b0;
      lat_dev   <= 7'h00;
      lat_reg   <= 8'h00;
      lat_wdata <= 8'h00;
      rdata_q   <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      step      <= step_d;
      tmo       <= tmo_d;
      owner     <= owner_d;
      last      <= last_d;
      lat_rw    <= lat_rw_d;
      lat_dev   <= lat_dev_d;
      lat_reg   <= lat_reg_d;
      lat_wdata <= lat_wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: a behavioural byte engine records every
// accepted command; transactions come from a vector table plus hand sequences
// for round-robin, timeout and mid-transaction reset.
module tb_i2c_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_rw;
  logic [13:0] req_dev;
  logic [15:0] req_reg, req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  logic [2:0]  eng_cmd;
  logic        eng_cmd_valid, eng_cmd_ready;
  logic [7:0]  eng_wdata;
  logic        eng_nack, eng_done, eng_ack;
  logic [7:0]  eng_rdata;
  logic        busy;

  i2c_cmd_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_dev(req_dev),
    .req_reg(req_reg), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .eng_cmd(eng_cmd), .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_wdata(eng_wdata), .eng_nack(eng_nack), .eng_done(eng_done),
    .eng_ack(eng_ack), .eng_rdata(eng_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Engine model: command log (oldest in the high bits) and response knobs.
  logic [20:0] tr_cmd;
  logic [55:0] tr_byte;
  logic [6:0]  tr_nack;
  int          log_n;
  int          nack_idx     = -1;
  int          withhold_idx = -1;
  logic [7:0]  v_erd        = 8'h00;
  bit          mon_en       = 1'b0;

  task automatic clear_log();
    tr_cmd = '0; tr_byte = '0; tr_nack = '0; log_n = 0;
  endtask

  // Accept one command, then pulse done two cycles later unless withheld.
  initial begin
    bit         pend = 1'b0;
    int         dly = 0;
    int         acc_idx = 0;
    logic [2:0] acc_cmd = 3'd0;
    eng_cmd_ready = 1'b0; eng_done = 1'b0; eng_ack = 1'b0; eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      eng_cmd_ready = 1'b0; eng_done = 1'b0; eng_ack = 1'b0; eng_rdata = 8'h00;
      if (pend) begin
        if (dly > 0) dly--;
        else begin
          pend = 1'b0;
          if (acc_idx != withhold_idx) begin
            eng_done  = 1'b1;
            eng_ack   = (acc_idx != nack_idx);
            eng_rdata = (acc_cmd == 3'd3) ? v_erd : 8'hEE;
          end
        end
      end else if (eng_cmd_valid === 1'b1) begin
        tr_cmd  = {tr_cmd[17:0], eng_cmd};
        tr_byte = {tr_byte[47:0], (eng_cmd == 3'd2) ? eng_wdata : 8'h00};
        tr_nack = {tr_nack[5:0], eng_nack};
        acc_idx = log_n;
        acc_cmd = eng_cmd;
        log_n++;
        eng_cmd_ready = 1'b1;
        pend = 1'b1;
        dly  = 1;
      end
    end
  end

  // Outside command issue the engine command lines must be quiet.
  initial begin
    forever begin
      tick();
      if (mon_en && eng_cmd_valid !== 1'b1) check("eng_quiet", {eng_cmd, eng_nack}, 64'h0);
    end
  end

  typedef struct {
    logic        who;
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  wd;
    logic [7:0]  erd;
    int          nack_at;
    logic [20:0] ecmd;
    logic [55:0] ebyte;
    logic [6:0]  enack;
    logic        err;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_grant(input logic [1:0] exp, input string name);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (|req_ready) break;
      tick();
    end
    check(name, req_ready, exp);
  endtask

  task automatic wait_rsp(input logic [1:0] exp, input string name);
    for (int c = 0; c < 300; c++) begin
      tick();
      if (|rsp_valid) break;
    end
    check(name, rsp_valid, exp);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [1:0] mask;
    v = vecs[i];
    mask = v.who ? 2'b10 : 2'b01;
    nack_idx = v.nack_at; withhold_idx = -1; v_erd = v.erd;
    clear_log();
    req_rw = {v.rw, v.rw};
    req_dev = {v.dev, v.dev}; req_reg = {v.rg, v.rg}; req_wdata = {v.wd, v.wd};
    req_valid = mask;
    wait_grant(mask, $sformatf("v%0d_grant", i));
    @(posedge clk); #1;
    req_valid = 2'b00;
    // Later requester-input changes must not disturb the latched transaction.
    req_dev = 14'($urandom); req_reg = 16'($urandom);
    req_wdata = 16'($urandom); req_rw = ~req_rw;
    wait_rsp(mask, $sformatf("v%0d_rsp_valid", i));
    check($sformatf("v%0d_rsp_err", i), rsp_err, v.err);
    check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v.rdata);
    check($sformatf("v%0d_cmds", i), tr_cmd, v.ecmd);
    check($sformatf("v%0d_bytes", i), tr_byte, v.ebyte);
    check($sformatf("v%0d_nack", i), tr_nack, v.enack);
    tick();
    check($sformatf("v%0d_busy_after", i), busy, 1'b0);
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [55:0] exp_b;

    vecs[0] = '{1'b0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1,
                {3'd1,3'd2,3'd2,3'd2,3'd4}, {8'h00,8'hA0,8'h10,8'hA5,8'h00},
                7'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 7'h68, 8'h75, 8'h00, 8'h3C, -1,
                {3'd1,3'd2,3'd2,3'd1,3'd2,3'd3,3'd4},
                {8'h00,8'hD0,8'h75,8'h00,8'hD1,8'h00,8'h00},
                7'b0000010, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1,
                {3'd1,3'd2,3'd4}, {8'h00,8'hA0,8'h00},
                7'b0, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 7'h2A, 8'h33, 8'h00, 8'h5A, 4,
                {3'd1,3'd2,3'd2,3'd1,3'd2,3'd4},
                {8'h00,8'h54,8'h33,8'h00,8'h55,8'h00},
                7'b0, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, 3,
                {3'd1,3'd2,3'd2,3'd2,3'd4}, {8'h00,8'hFE,8'hFF,8'h00,8'h00},
                7'b0, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 7'h00, 8'h00, 8'h00, 8'hFF, -1,
                {3'd1,3'd2,3'd2,3'd1,3'd2,3'd3,3'd4},
                {8'h00,8'h00,8'h00,8'h00,8'h01,8'h00,8'h00},
                7'b0000010, 1'b0, 8'hFF};

    reset = 1'b1; req_valid = 2'b00; req_rw = 2'b00;
    req_dev = '0; req_reg = '0; req_wdata = '0;
    clear_log();
    tick(); tick();
    check("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, eng_cmd,
                            eng_cmd_valid, eng_wdata, eng_nack, busy}, 64'h0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // Both requesting continuously: req0, req1, req0, each re-arbitrated in
    // the IDLE cycle right after the previous response.
    req_rw = 2'b00; req_dev = {7'h20, 7'h10};
    req_reg = {8'h02, 8'h01}; req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    wait_grant(2'b01, "rr_first_grant");
    for (int k = 0; k < 3; k++) begin
      exp_g = (k == 1) ? 2'b10 : 2'b01;
      exp_b = (k == 1) ? {8'h00,8'h40,8'h02,8'h22,8'h00} : {8'h00,8'h20,8'h01,8'h11,8'h00};
      if (k > 0) check($sformatf("rr_grant%0d", k), req_ready, exp_g);
      clear_log();
      @(posedge clk); #1;
      wait_rsp(exp_g, $sformatf("rr_rsp%0d", k));
      if (k == 2) req_valid = 2'b00;
      check($sformatf("rr_bytes%0d", k), tr_byte, exp_b);
      tick();
    end

    for (int i = 0; i < 6; i++) run_vec(i);

    // Timeout: START never completes; response on cycle 17 after acceptance.
    nack_idx = -1; withhold_idx = 0; clear_log();
    req_rw = 2'b00; req_dev = {7'h00, 7'h50}; req_reg = 16'h0010; req_wdata = 16'h00A5;
    req_valid = 2'b01;
    wait_grant(2'b01, "tmo_grant");
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int c = 0; c < 20; c++) begin
      if (eng_cmd_ready === 1'b1) break;
      tick();
    end
    check("tmo_accept_seen", eng_cmd_ready, 1'b1);
    for (int c = 1; c <= 16; c++) tick();
    check("tmo_not_early", rsp_valid, 2'b00);
    tick();
    check("tmo_rsp_valid", rsp_valid, 2'b01);
    check("tmo_rsp_err", rsp_err, 1'b1);
    check("tmo_rsp_rdata", rsp_rdata, 8'h00);
    check("tmo_no_stop", tr_cmd, 21'd1);
    tick();
    check("tmo_busy_low", busy, 1'b0);

    // Reset while waiting on the READ of a read transaction.
    withhold_idx = 5; v_erd = 8'h3C; clear_log();
    req_rw = 2'b01; req_dev = {7'h00, 7'h68}; req_reg = 16'h0075;
    req_valid = 2'b01;
    wait_grant(2'b01, "rst_grant");
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int c = 0; c < 100; c++) begin
      if (log_n == 6 && eng_cmd_valid === 1'b0) break;
      tick();
    end
    check("rst_reached_read_wait", log_n, 6);
    reset = 1'b1;
    tick();
    check("rst_mid_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, eng_cmd,
                              eng_cmd_valid, eng_wdata, eng_nack, busy}, 64'h0);
    reset = 1'b0; withhold_idx = -1;
    tick(); tick(); tick();
    check("rst_no_stop", log_n, 6);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, max clk cycles allowed per engine command before abort.
REQ-002 SHALL have ports, in this order:
- clk, input, 1, clock
- reset, input, 1, reset, synchronous, active-high; clock clk
- req_valid, input, 2, per-requester transaction request (bit i = requester i)
- req_rw, input, 2, per-requester direction, 0=write, 1=read
- req_dev, input, 14, 7-bit device address per requester, [6:0]=req0, [13:7]=req1
- req_reg, input, 16, register address byte per requester, [7:0]=req0
- req_wdata, input, 16, write data byte per requester, [7:0]=req0
- req_ready, output, 2, one-cycle accept pulse to granted requester
- rsp_valid, output, 2, one-cycle completion pulse to owning requester
- rsp_err, output, 1, error flag, valid with rsp_valid
- rsp_rdata, output, 8, read data, valid with rsp_valid
- eng_cmd, output, 3, 1=START, 2=WRITE, 3=READ, 4=STOP, 0=none
- eng_cmd_valid, output, 1, command request to byte engine
- eng_cmd_ready, input, 1, engine accepts command
- eng_wdata, output, 8, byte for WRITE
- eng_nack, output, 1, master NACK on READ
- eng_done, input, 1, one-cycle pulse, command finished
- eng_ack, input, 1, slave ACK, valid with eng_done after WRITE
- eng_rdata, input, 8, read byte, valid with eng_done after READ
- busy, output, 1, high from grant until response

Function
REQ-003 SHALL arbitrate round-robin in IDLE: when both req_valid bits are high, grant the requester not served last; last-served pointer resets to 1, so req0 wins first.
REQ-004 SHALL pulse req_ready[i] in the grant cycle and latch dev/reg/wdata/rw of requester i; later changes on requester inputs SHALL be ignored.
REQ-005 SHALL hold the grant until rsp_valid is issued; no preemption.
REQ-006 SHALL sequence writes: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP.
REQ-007 SHALL sequence reads: START, WRITE {dev,0}, WRITE reg, START (repeated), WRITE {dev,1}, READ with eng_nack=1, STOP.
REQ-008 SHALL use per-command handshake: assert eng_cmd_valid with stable eng_cmd/eng_wdata until the cycle eng_cmd_ready=1, then deassert and wait for eng_done; next command no earlier than the cycle after eng_done.
REQ-009 SHALL keep eng_cmd=0, eng_cmd_valid=0, eng_nack=0 outside command issue.
REQ-010 SHALL, on eng_done after WRITE with eng_ack=0, skip remaining bytes, issue STOP, and respond with rsp_err=1.
REQ-011 SHALL run a 16-bit timeout counter, cleared at each command issue; on reaching TIMEOUT_CYCLES without eng_done it SHALL abandon the command, drive no STOP, and respond with rsp_err=1.
REQ-012 SHALL pulse rsp_valid[owner] one cycle after STOP's eng_done; rsp_rdata = captured read byte (reads), 8'h00 (writes/errors).
REQ-013 SHALL return to IDLE the cycle after rsp_valid; a request pending then SHALL be arbitrated in that IDLE cycle.
REQ-014 SHALL ignore eng_done outside the wait state of an issued command.
REQ-015 SHALL have states IDLE, ISSUE, WAIT, RESP; a sequence-step counter (0..6) selects the command; NACK sets the step to STOP.

Reset
REQ-016 SHALL, with reset high at a clk edge, go to IDLE, clear step/timeout counters, set last-served to 1, drive all outputs 0, regardless of transaction in progress.
REQ-017 SHALL NOT issue STOP after reset; bus recovery belongs to the engine.

Verification
REQ-018 Write req0 dev=7'h50 reg=8'h10 wdata=8'hA5, engine always acks -> bytes 8'hA0,8'h10,8'hA5 between START/STOP; rsp_valid=2'b01, rsp_err=0.
REQ-019 Read req1 dev=7'h68 reg=8'h75, engine eng_rdata=8'h3C -> bytes 8'hD0,8'h75, repeated START, 8'hD1, READ with eng_nack=1, STOP; rsp_valid=2'b10, rsp_rdata=8'h3C.
REQ-020 req_valid=2'b11 held across three transactions -> grants req0, req1, req0.
REQ-021 eng_ack=0 on device byte -> no reg byte, STOP issued, rsp_err=1, rsp_rdata=8'h00.
REQ-022 TIMEOUT_CYCLES=16, eng_done withheld after START -> rsp_err=1 on cycle 17 after issue acceptance, busy low next cycle.
REQ-023 reset asserted mid-read during WAIT -> next cycle all outputs 0, IDLE; new req0 then grants normally.
